// File: rtl/demux_pkg.sv
// Shared select encoding for the 1-to-3 stream demultiplexer.
package demux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_Y0   = 2'd0;
  localparam sel_t SEL_Y1   = 2'd1;
  localparam sel_t SEL_Y2   = 2'd2;
  localparam sel_t SEL_DROP = 2'd3;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready output register; accepts a push in the same cycle
// as a pop so a single output can sustain one beat per clock.
module demux_out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             free
);

  assign free = ~valid | ready;

  // The top only pushes when free, so push always wins over a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (push) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1x3_stream.sv
// Registered 1-to-3 stream demultiplexer with per-output valid/ready slots;
// select code 3 discards the beat and bumps a saturating drop counter.
module demux1x3_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  sel_t       sel;
  logic [2:0] free;
  logic [2:0] push;
  logic       accept;
  logic       drop_accept;

  assign sel = {s1, s0};

  // Ready only looks at the selected slot, so a stalled output never blocks
  // beats routed elsewhere; drops are always accepted outside reset.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (sel)
        SEL_Y0:  in_ready = free[0];
        SEL_Y1:  in_ready = free[1];
        SEL_Y2:  in_ready = free[2];
        default: in_ready = 1'b1;
      endcase
    end
  end

  assign accept      = in_valid & in_ready;
  assign push[0]     = accept & (sel == SEL_Y0);
  assign push[1]     = accept & (sel == SEL_Y1);
  assign push[2]     = accept & (sel == SEL_Y2);
  assign drop_accept = accept & (sel == SEL_DROP);

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[0]),
    .d     (i),
    .ready (r0),
    .valid (v0),
    .q     (y0),
    .free  (free[0])
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[1]),
    .d     (i),
    .ready (r1),
    .valid (v1),
    .q     (y1),
    .free  (free[1])
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push[2]),
    .d     (i),
    .ready (r2),
    .valid (v2),
    .q     (y2),
    .free  (free[2])
  );

  // Drop counter saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop_accept;
      if (drop_accept && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
